// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution event path.
// The dispatcher, its window-bounds helper and later pooling stages all use them.
package conv_pkg;

    localparam int COORD_WIDTH_DEF = 5;

    typedef struct packed {
        logic [COORD_WIDTH_DEF-1:0] x;
        logic [COORD_WIDTH_DEF-1:0] y;
    } event_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SCAN
    } disp_state_e;

    function automatic int clip(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/conv_event_dispatcher_if.sv
// Event-FIFO pop side plus the membrane-update beat stream of the dispatcher.
interface conv_event_dispatcher_if #(
    parameter int COORD_WIDTH = 5,
    parameter int KERNEL_SIZE = 3
);
    localparam int KW          = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam int EVENT_WIDTH = 2 * COORD_WIDTH;

    logic                   fifo_read_en;
    logic [EVENT_WIDTH-1:0] fifo_read_data;
    logic                   fifo_empty;
    logic                   upd_valid;
    logic                   upd_ready;
    logic [COORD_WIDTH-1:0] upd_x;
    logic [COORD_WIDTH-1:0] upd_y;
    logic [KW-1:0]          upd_kx;
    logic [KW-1:0]          upd_ky;
    logic                   upd_last;
    logic                   busy;
    logic                   drop_err;

    modport master (
        output fifo_read_en, input fifo_read_data, input fifo_empty,
        output upd_valid, input upd_ready,
        output upd_x, output upd_y, output upd_kx, output upd_ky, output upd_last,
        output busy, output drop_err
    );

    modport slave (
        input fifo_read_en, output fifo_read_data, output fifo_empty,
        input upd_valid, output upd_ready,
        input upd_x, input upd_y, input upd_kx, input upd_ky, input upd_last,
        input busy, input drop_err
    );

endinterface

// File: rtl/conv_window_bounds.sv
// Combinational K x K window around (x, y), clipped to the feature map.
// in_range_o flags coordinates that actually lie inside the map.
module conv_window_bounds import conv_pkg::*; #(
    parameter int IMG_WIDTH   = 32,
    parameter int IMG_HEIGHT  = 32,
    parameter int COORD_WIDTH = 5,
    parameter int KERNEL_SIZE = 3
) (
    input  logic [COORD_WIDTH-1:0] x_i,
    input  logic [COORD_WIDTH-1:0] y_i,
    output logic [COORD_WIDTH-1:0] x_lo_o,
    output logic [COORD_WIDTH-1:0] x_hi_o,
    output logic [COORD_WIDTH-1:0] y_lo_o,
    output logic [COORD_WIDTH-1:0] y_hi_o,
    output logic                   in_range_o
);
    localparam int R  = KERNEL_SIZE / 2;
    localparam int SW = COORD_WIDTH + 2;

    // Two extra bits keep x-R from wrapping near the origin.
    logic signed [SW-1:0] xs, ys, rs;

    assign xs = $signed({2'b00, x_i});
    assign ys = $signed({2'b00, y_i});
    assign rs = SW'(R);

    assign x_lo_o     = COORD_WIDTH'(clip(int'(xs - rs), 0, IMG_WIDTH - 1));
    assign x_hi_o     = COORD_WIDTH'(clip(int'(xs + rs), 0, IMG_WIDTH - 1));
    assign y_lo_o     = COORD_WIDTH'(clip(int'(ys - rs), 0, IMG_HEIGHT - 1));
    assign y_hi_o     = COORD_WIDTH'(clip(int'(ys + rs), 0, IMG_HEIGHT - 1));
    assign in_range_o = (int'(xs) < IMG_WIDTH) && (int'(ys) < IMG_HEIGHT);

endmodule

// File: rtl/conv_event_dispatcher.sv
// Expands each spike event into the clipped K x K sequence of membrane-update beats,
// row-major, prefetching the next event on the last beat handshake.
module conv_event_dispatcher import conv_pkg::*; #(
    parameter int IMG_WIDTH   = 32,
    parameter int IMG_HEIGHT  = 32,
    parameter int COORD_WIDTH = 5,
    parameter int KERNEL_SIZE = 3,
    parameter int EVENT_WIDTH = 2 * COORD_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    conv_event_dispatcher_if.master bus
);
    localparam int R  = KERNEL_SIZE / 2;
    localparam int KW = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam int SW = COORD_WIDTH + 2;

    disp_state_e state_q, state_d;
    logic [COORD_WIDTH-1:0] ex_q, ex_d, ey_q, ey_d;
    logic [COORD_WIDTH-1:0] xlo_q, xlo_d, xhi_q, xhi_d, ylo_q, ylo_d, yhi_q, yhi_d;
    logic [COORD_WIDTH-1:0] ox_q, ox_d, oy_q, oy_d;
    logic                   drop_q, drop_d;
    logic                   rd_en, last, scan;

    logic [COORD_WIDTH-1:0] ev_x, ev_y, b_xlo, b_xhi, b_ylo, b_yhi;
    logic                   b_in;

    assign ev_x = bus.fifo_read_data[EVENT_WIDTH-1 -: COORD_WIDTH];
    assign ev_y = bus.fifo_read_data[COORD_WIDTH-1:0];

    conv_window_bounds #(
        .IMG_WIDTH(IMG_WIDTH), .IMG_HEIGHT(IMG_HEIGHT),
        .COORD_WIDTH(COORD_WIDTH), .KERNEL_SIZE(KERNEL_SIZE)
    ) u_bounds (
        .x_i(ev_x), .y_i(ev_y),
        .x_lo_o(b_xlo), .x_hi_o(b_xhi), .y_lo_o(b_ylo), .y_hi_o(b_yhi),
        .in_range_o(b_in)
    );

    assign scan = (state_q == SCAN);
    assign last = (ox_q == xhi_q) && (oy_q == yhi_q);

    always_comb begin
        state_d = state_q;
        ex_d    = ex_q;
        ey_d    = ey_q;
        xlo_d   = xlo_q;
        xhi_d   = xhi_q;
        ylo_d   = ylo_q;
        yhi_d   = yhi_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        drop_d  = drop_q;
        rd_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.fifo_empty) begin
                    rd_en   = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                ex_d = ev_x;
                ey_d = ev_y;
                if (!b_in) begin
                    drop_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    xlo_d   = b_xlo;
                    xhi_d   = b_xhi;
                    ylo_d   = b_ylo;
                    yhi_d   = b_yhi;
                    ox_d    = b_xlo;
                    oy_d    = b_ylo;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (bus.upd_ready) begin
                    if (last) begin
                        if (!bus.fifo_empty) begin
                            rd_en   = 1'b1;
                            state_d = FETCH;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (ox_q == xhi_q) begin
                        ox_d = xlo_q;
                        oy_d = oy_q + 1'b1;
                    end else begin
                        ox_d = ox_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ex_q    <= '0;
            ey_q    <= '0;
            xlo_q   <= '0;
            xhi_q   <= '0;
            ylo_q   <= '0;
            yhi_q   <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ex_q    <= ex_d;
            ey_q    <= ey_d;
            xlo_q   <= xlo_d;
            xhi_q   <= xhi_d;
            ylo_q   <= ylo_d;
            yhi_q   <= yhi_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            drop_q  <= drop_d;
        end
    end

    // Kernel index = centre - target + R, always within 0..K-1.
    logic signed [SW-1:0] kx_s, ky_s;
    assign kx_s = $signed({2'b00, ex_q}) - $signed({2'b00, ox_q}) + SW'(R);
    assign ky_s = $signed({2'b00, ey_q}) - $signed({2'b00, oy_q}) + SW'(R);

    // Gating with rst keeps the pop request low while reset holds the FSM in IDLE.
    assign bus.fifo_read_en = rd_en & ~rst;
    assign bus.upd_valid    = scan;
    assign bus.upd_x        = scan ? ox_q : '0;
    assign bus.upd_y        = scan ? oy_q : '0;
    assign bus.upd_kx       = scan ? KW'(kx_s) : '0;
    assign bus.upd_ky       = scan ? KW'(ky_s) : '0;
    assign bus.upd_last     = scan & last;
    assign bus.busy         = (state_q != IDLE);
    assign bus.drop_err     = drop_q;

endmodule

// File: tb/tb_conv_event_dispatcher.sv
// Directed bench for conv_event_dispatcher on a 32x32 map with 6-bit coordinates
// so that an out-of-range x (40) can be presented.
module tb_conv_event_dispatcher;
    localparam int CW = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    conv_event_dispatcher_if #(.COORD_WIDTH(CW), .KERNEL_SIZE(3)) bus ();

    conv_event_dispatcher #(
        .IMG_WIDTH(32), .IMG_HEIGHT(32), .COORD_WIDTH(CW), .KERNEL_SIZE(3), .EVENT_WIDTH(2*CW)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    // Event FIFO model: data appears the cycle after an accepted pop.
    logic [2*CW-1:0] fmem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign bus.fifo_empty = (wr_ptr == rd_ptr);
    initial bus.fifo_read_data = '0;
    always @(posedge clk) begin
        if (bus.fifo_read_en && (wr_ptr != rd_ptr)) begin
            bus.fifo_read_data <= fmem[rd_ptr];
            rd_ptr <= rd_ptr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int x, input int y);
        fmem[wr_ptr] = {CW'(x), CW'(y)};
        wr_ptr++;
    endtask

    // Walks the hand-given window row-major, checking each beat at its handshake.
    task automatic run_event(input int x, input int y, input int xlo, input int xhi,
                             input int ylo, input int yhi, input bit rnd, output int first_wait);
        int guard;
        bit first;
        logic [2*CW+4:0] exp_v, obs_v;
        first = 1'b1;
        first_wait = -1;
        for (int oy = ylo; oy <= yhi; oy++) begin
            for (int ox = xlo; ox <= xhi; ox++) begin
                guard = 0;
                forever begin
                    bus.upd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                    if (bus.upd_valid && bus.upd_ready) break;
                    if (guard == 60) break;
                    guard++;
                    @(negedge clk);
                end
                if (guard == 60) begin
                    chk($sformatf("timeout ev(%0d,%0d)", x, y), 32'd0, 32'd1);
                    return;
                end
                if (first) first_wait = guard;
                first = 1'b0;
                exp_v = {CW'(ox), CW'(oy), 2'(x - ox + 1), 2'(y - oy + 1),
                         1'((ox == xhi) && (oy == yhi))};
                obs_v = {bus.upd_x, bus.upd_y, bus.upd_kx, bus.upd_ky, bus.upd_last};
                chk($sformatf("beat ev(%0d,%0d) o(%0d,%0d)", x, y, ox, oy), 32'(obs_v), 32'(exp_v));
                @(negedge clk);
            end
        end
    endtask

    // Stall stability and pop legality, sampled mid-low-phase.
    logic [2*CW+5:0] hold_q;
    logic [2*CW+5:0] cur;
    bit              stall_q = 1'b0;
    always @(negedge clk) begin
        #2;
        cur = {bus.upd_valid, bus.upd_x, bus.upd_y, bus.upd_kx, bus.upd_ky, bus.upd_last};
        if (!rst) begin
            if (stall_q) chk("stall_hold", 32'(cur), 32'(hold_q));
            if (bus.fifo_read_en)
                chk("pop_legal", {30'd0, !bus.fifo_empty,
                    (!bus.busy || (bus.upd_valid && bus.upd_ready && bus.upd_last))}, 32'd3);
        end
        stall_q = !rst && bus.upd_valid && !bus.upd_ready;
        hold_q  = cur;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int w, w2;
        bus.upd_ready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", bus.upd_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_drop", bus.drop_err, 0);
        chk("rst_rden", bus.fifo_read_en, 0);
        chk("rst_x", bus.upd_x, 0);
        chk("rst_kx", bus.upd_kx, 0);
        chk("rst_last", bus.upd_last, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_rden_empty", bus.fifo_read_en, 0);

        // Interior event: full 3x3 window, latency of two cycles after the pop.
        push(10, 10);
        #1;
        chk("pop_req", bus.fifo_read_en, 1);
        run_event(10, 10, 9, 11, 9, 11, 1'b0, w);
        chk("latency", w, 2);
        chk("idle_valid", bus.upd_valid, 0);
        chk("idle_busy", bus.busy, 0);

        // Corner and right-edge clipping.
        push(0, 0);
        run_event(0, 0, 0, 1, 0, 1, 1'b0, w);
        push(31, 5);
        run_event(31, 5, 30, 31, 4, 6, 1'b0, w);

        // Out-of-range event is dropped; drop_err is sticky.
        push(40, 3);
        repeat (4) begin
            @(negedge clk);
            chk("drop_novalid", bus.upd_valid, 0);
        end
        chk("drop_err", bus.drop_err, 1);
        chk("drop_idle", bus.busy, 0);
        push(5, 5);
        run_event(5, 5, 4, 6, 4, 6, 1'b0, w);
        chk("drop_sticky", bus.drop_err, 1);

        // Three queued events under pseudo-random backpressure.
        push(2, 2);
        push(20, 20);
        push(31, 31);
        run_event(2, 2, 1, 3, 1, 3, 1'b1, w);
        run_event(20, 20, 19, 21, 19, 21, 1'b1, w);
        run_event(31, 31, 30, 31, 30, 31, 1'b1, w);
        bus.upd_ready = 1'b1;
        @(negedge clk);
        chk("rnd_done_busy", bus.busy, 0);

        // Back-to-back with ready high: exactly one bubble cycle.
        push(3, 3);
        push(4, 4);
        run_event(3, 3, 2, 4, 2, 4, 1'b0, w);
        chk("b2b_bubble_valid", bus.upd_valid, 0);
        chk("b2b_bubble_busy", bus.busy, 1);
        run_event(4, 4, 3, 5, 3, 5, 1'b0, w2);
        chk("b2b_gap", w2, 1);

        // Reset during the 4th beat of (10,10); (7,7) must survive in the FIFO.
        push(10, 10);
        push(7, 7);
        w = 0;
        while (!bus.upd_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        chk("beat4_xy", {bus.upd_x, bus.upd_y}, {CW'(9), CW'(10)});
        rst = 1'b1;
        #1;
        chk("arst_valid", bus.upd_valid, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_x", bus.upd_x, 0);
        chk("arst_rden", bus.fifo_read_en, 0);
        @(negedge clk);
        rst = 1'b0;
        run_event(7, 7, 6, 8, 6, 8, 1'b0, w);
        chk("post_rst_latency", w, 2);
        chk("post_rst_drop", bus.drop_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/conv_event_dispatcher.md
# conv_event_dispatcher

Consumes spike events from the convolution stage's input event FIFO and expands each event into the sequence of output-neuron membrane update requests covered by the K×K kernel. The window is clipped at the feature-map borders. Sits directly downstream of the event FIFO (pop side) and upstream of the membrane-update/weight-lookup stage. It converts one event into up to K² valid/ready update beats.

## Interface
Parameters:
- IMG_WIDTH, 32, feature-map width in neurons
- IMG_HEIGHT, 32, feature-map height in neurons
- COORD_WIDTH, 5, bits per coordinate; must satisfy 2**COORD_WIDTH ≥ max(IMG_WIDTH, IMG_HEIGHT)
- KERNEL_SIZE, 3, odd kernel edge K; R = K/2
- EVENT_WIDTH, 2*COORD_WIDTH, FIFO word width

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- fifo_read_en  out  1  pop request to event FIFO
- fifo_read_data  in  EVENT_WIDTH  event {x[MSB half], y[LSB half]}; valid the cycle after an accepted pop
- fifo_empty  in  1  FIFO empty flag
- upd_valid  out  1  update beat valid
- upd_ready  in  1  downstream accepts beat
- upd_x, upd_y  out  COORD_WIDTH  target output neuron
- upd_kx, upd_ky  out  $clog2(K)  kernel weight index
- upd_last  out  1  final beat of current event
- busy  out  1  state ≠ IDLE
- drop_err  out  1  sticky: an out-of-range event was dropped

## Operation
- FSM states: IDLE, FETCH, SCAN.
- IDLE: fifo_read_en = !fifo_empty (combinational). If asserted, go to FETCH.
- FETCH: capture fifo_read_data as (x, y).
  - If x ≥ IMG_WIDTH or y ≥ IMG_HEIGHT: set drop_err, go to IDLE, emit no beats.
  - Otherwise register the clipped window and go to SCAN:
    - x_lo = max(x−R, 0), x_hi = min(x+R, IMG_WIDTH−1)
    - y_lo and y_hi computed the same way, clipped to IMG_HEIGHT−1
    - Initialise the counters ox = x_lo, oy = y_lo.
- SCAN: upd_valid = 1.
  - upd_x = ox, upd_y = oy
  - upd_kx = x − ox + R, upd_ky = y − oy + R
  - Order: oy outer, ox inner, both ascending.
  - upd_last = (ox == x_hi && oy == y_hi).
  - On each handshake (upd_valid && upd_ready), advance ox. On ox == x_hi, wrap ox to x_lo and increment oy.
- Last-beat handshake:
  - If !fifo_empty, assert fifo_read_en in that same cycle and go to FETCH (prefetch).
  - Otherwise go to IDLE.
- fifo_read_en is never asserted while fifo_empty, and never outside IDLE or the SCAN last handshake.
- Arithmetic: window bounds use signed COORD_WIDTH+2 intermediates so x−R never wraps. Kernel indices are always in 0..K−1.
- drop_err clears only on rst.

## Timing
- Reset values: state IDLE; upd_valid, upd_last, fifo_read_en, busy, drop_err all 0; upd_x/y/kx/ky all 0.
- Latency: pop cycle (fifo_read_en = 1) is T → FETCH at T+1 → first upd_valid at T+2.
- Beats per event = (x_hi−x_lo+1)·(y_hi−y_lo+1), between 1 and K².
- Back-to-back events: exactly one bubble cycle (FETCH) between the last beat of one event and the first beat of the next.
- Backpressure: while upd_valid && !upd_ready, all upd_* outputs hold stable and no pop occurs.
- Reset asserted mid-SCAN or mid-FETCH: outputs return to reset values immediately (asynchronous). The in-flight event is lost; the FIFO is not re-read.

## Structure
- Shared package conv_pkg holds:
  - the event typedef (struct {x, y})
  - the dispatcher state enum
  - a clip helper function
- Sub-module conv_window_bounds: combinational (x, y) → {x_lo, x_hi, y_lo, y_hi, in_range}, reused by later pooling stages.

## Test plan
- Event (10,10), K=3, 32×32, ready=1 → 9 beats.
  - First beat: (9,9) k(2,2).
  - Last beat: (11,11) k(0,0), upd_last=1.
- Event (0,0) → 4 beats in order, upd_last only on the final beat:
  - (0,0) k(1,1)
  - (1,0) k(0,1)
  - (0,1) k(1,0)
  - (1,1) k(0,0)
- Event (31,5) → 6 beats, ox ∈ {30,31}, oy ∈ {4,5,6}.
- Event x=40 → zero beats; drop_err=1 and stays 1; next valid event is processed normally.
- Three events queued, upd_ready toggled pseudo-randomly.
  - upd_* outputs stable during stalls.
  - fifo_read_en pulses only on last-beat handshakes.
  - Exactly one idle cycle between events when ready=1.
- rst pulsed during the 4th beat of an event.
  - upd_valid falls to 0 the same cycle.
  - After release, the next FIFO event starts cleanly with its correct first beat.
